// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronizes, debounces and edge-detects raw push-button inputs.
//            Optional macro BUTTON_CONDITIONER_FALLING_EDGE_EN enables falling_pulse.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int WIDTH          = 3,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] button_in,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rising_pulse,
    output logic [WIDTH-1:0] falling_pulse
);

    localparam int c_SW = $clog2(SAMPLE_CNT_MAX);
    localparam int c_PW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [c_SW-1:0] c_TICK_LAST = c_SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [c_PW-1:0] c_PULSE_MAX = c_PW'(PULSE_CNT_MAX);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [c_SW-1:0]  sample_cnt_q;
    logic [c_SW-1:0]  sample_cnt_d;
    logic             w_tick;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_dly_q;

    // Plain two-flop synchronizer; nothing may sit between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= button_in;
            sync2_q <= sync1_q;
        end
    end

    assign w_tick = (sample_cnt_q == c_TICK_LAST);

    always_comb begin
        sample_cnt_d = sample_cnt_q + c_SW'(1);
        if (w_tick) begin
            sample_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [c_PW-1:0] cnt_q;
        logic [c_PW-1:0] cnt_d;

        // A single low sample releases; presses need PULSE_CNT_MAX high ticks.
        always_comb begin
            cnt_d = cnt_q;
            if (!sync2_q[i]) begin
                cnt_d = '0;
            end else if (w_tick && (cnt_q != c_PULSE_MAX)) begin
                cnt_d = cnt_q + c_PW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign deb_d[i] = (cnt_d == c_PULSE_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q     <= '0;
            deb_dly_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
        end
    end

    assign debounced    = deb_q;
    assign rising_pulse = deb_q & ~deb_dly_q;

`ifdef BUTTON_CONDITIONER_FALLING_EDGE_EN
    assign falling_pulse = ~deb_q & deb_dly_q;
`else
    assign falling_pulse = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Directed self-checking bench for button_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int W = 3;
`ifdef BUTTON_CONDITIONER_FALLING_EDGE_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] button_in = '0;
    logic [W-1:0] debounced;
    logic [W-1:0] rising_pulse;
    logic [W-1:0] falling_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int n_rise   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .WIDTH         (W),
        .SAMPLE_CNT_MAX(4),
        .PULSE_CNT_MAX (3)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .button_in    (button_in),
        .debounced    (debounced),
        .rising_pulse (rising_pulse),
        .falling_pulse(falling_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_cycle(input string t, input int c, input logic [W-1:0] e_deb,
                             input logic [W-1:0] e_rise, input logic [W-1:0] e_fall);
        chk($sformatf("%s deb c%0d", t, c), 32'(debounced), 32'(e_deb));
        chk($sformatf("%s rise c%0d", t, c), 32'(rising_pulse), 32'(e_rise));
        chk($sformatf("%s fall c%0d", t, c), 32'(falling_pulse), 32'(e_fall));
        if (rising_pulse != '0) n_rise++;
    endtask

    // Asserts rst mid-cycle (checks the asynchronous clear), holds two edges,
    // then releases mid-cycle so the next negedge lies in cycle 0.
    task automatic apply_reset(input string t);
        rst = 1'b1;
        #1;
        chk_cycle({t, " rst_async"}, 0, '0, '0, '0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_cycle({t, " rst_hold"}, 0, '0, '0, '0);
        end
        #1 rst = 1'b0;
        n_rise = 0;
    endtask

    initial begin
        // Clean press on channel 0, then release at cycle 20
        button_in = 3'b001;
        @(negedge clk);
        apply_reset("t1");
        for (int c = 0; c <= 26; c++) begin
            @(negedge clk);
            chk_cycle("t1", c, (c >= 12 && c < 23) ? 3'b001 : 3'b000,
                      (c == 12) ? 3'b001 : 3'b000,
                      (FALL_EN && c == 23) ? 3'b001 : 3'b000);
            if (c == 20) button_in = 3'b000;
        end

        // Bounce on channel 1: one low cycle at cycle 9 restarts qualification
        button_in = 3'b010;
        apply_reset("t2");
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            chk_cycle("t2", c, (c >= 24) ? 3'b010 : 3'b000,
                      (c == 24) ? 3'b010 : 3'b000, 3'b000);
            if (c == 9)  button_in = 3'b000;
            if (c == 10) button_in = 3'b010;
        end
        chk("t2 rise_count", 32'(n_rise), 32'd1);

        // Simultaneous press on all channels
        button_in = 3'b111;
        apply_reset("t4");
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            chk_cycle("t4", c, (c >= 12) ? 3'b111 : 3'b000,
                      (c == 12) ? 3'b111 : 3'b000, 3'b000);
        end

        // Reset while debounced high, then mid-count at cycle 10, then re-qualify
        apply_reset("t5a");
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            chk_cycle("t5b", c, 3'b000, 3'b000, 3'b000);
        end
        apply_reset("t5c");
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            chk_cycle("t5d", c, (c >= 12) ? 3'b111 : 3'b000,
                      (c == 12) ? 3'b111 : 3'b000, 3'b000);
        end

        // Saturation: channel 2 held high well past qualification
        button_in = 3'b100;
        apply_reset("t6");
        for (int c = 0; c <= 111; c++) begin
            @(negedge clk);
            chk_cycle("t6", c, (c >= 12) ? 3'b100 : 3'b000,
                      (c == 12) ? 3'b100 : 3'b000, 3'b000);
        end
        chk("t6 rise_count", 32'(n_rise), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
